// File: rtl/panda_pkg.sv
// Shared types for the Panda Core fetch-stage PC unit.
// pc_sel_e encoding order is the redirect priority: higher value wins.
package panda_pkg;

  typedef enum logic [2:0] {
    PcSelInc    = 3'd0,
    PcSelBranch = 3'd1,
    PcSelJump   = 3'd2,
    PcSelMret   = 3'd3,
    PcSelTrap   = 3'd4
  } pc_sel_e;

  typedef enum logic [1:0] {
    PcBoot = 2'd0,
    PcRun  = 2'd1,
    PcHold = 2'd2
  } pc_state_e;

endpackage

// File: rtl/panda_pc_unit_if.sv
// Redirect, stall and fetch-request signals between execute/CSR logic,
// the PC unit and instruction memory. The PC unit takes the slave side.
interface panda_pc_unit_if #(
  parameter int Width = 32
);
  logic             stall_i;
  logic             branch_i;
  logic [Width-1:0] branch_target_i;
  logic             jump_i;
  logic [Width-1:0] jump_target_i;
  logic             mret_i;
  logic [Width-1:0] mepc_i;
  logic             trap_i;
  logic [Width-1:0] trap_vector_i;
  logic             fetch_ready_i;
  logic             fetch_valid_o;
  logic [Width-1:0] pc_o;
  logic [Width-1:0] pc_inc_o;
  logic             flush_o;
  logic             misaligned_o;
  logic [Width-1:0] badaddr_o;

  modport master (
    output stall_i, branch_i, branch_target_i, jump_i, jump_target_i,
           mret_i, mepc_i, trap_i, trap_vector_i, fetch_ready_i,
    input  fetch_valid_o, pc_o, pc_inc_o, flush_o, misaligned_o, badaddr_o
  );

  modport slave (
    input  stall_i, branch_i, branch_target_i, jump_i, jump_target_i,
           mret_i, mepc_i, trap_i, trap_vector_i, fetch_ready_i,
    output fetch_valid_o, pc_o, pc_inc_o, flush_o, misaligned_o, badaddr_o
  );
endinterface

// File: rtl/panda_pc_redirect_arb.sv
// Combinational redirect arbiter: alignment check/masking, priority select
// among the input requests, then select against the pending (stalled) entry.
module panda_pc_redirect_arb
  import panda_pkg::*;
#(
  parameter int Width     = 32,
  parameter int AlignBits = 2
) (
  input  logic             i_enable,
  input  logic             i_branch,
  input  logic [Width-1:0] i_branch_target,
  input  logic             i_jump,
  input  logic [Width-1:0] i_jump_target,
  input  logic             i_mret,
  input  logic [Width-1:0] i_mepc,
  input  logic             i_trap,
  input  logic [Width-1:0] i_trap_vector,
  input  pc_sel_e          i_pend_sel,
  input  logic [Width-1:0] i_pend_target,
  output pc_sel_e          o_sel,
  output logic [Width-1:0] o_target,
  output logic             o_misaligned,
  output logic [Width-1:0] o_badaddr
);

  localparam logic [Width-1:0] LowMask = (Width'(1) << AlignBits) - Width'(1);

  logic             w_branch_bad;
  logic             w_jump_bad;
  pc_sel_e          w_in_sel;
  logic [Width-1:0] w_in_target;

  assign w_branch_bad = |(i_branch_target & LowMask);
  assign w_jump_bad   = |(i_jump_target & LowMask);

  // A misaligned branch/jump simply drops out, letting lower requests through.
  always_comb begin
    w_in_sel    = PcSelInc;
    w_in_target = '0;
    if (i_enable) begin
      if (i_trap) begin
        w_in_sel    = PcSelTrap;
        w_in_target = i_trap_vector & ~LowMask;
      end else if (i_mret) begin
        w_in_sel    = PcSelMret;
        w_in_target = i_mepc & ~LowMask;
      end else if (i_jump && !w_jump_bad) begin
        w_in_sel    = PcSelJump;
        w_in_target = i_jump_target;
      end else if (i_branch && !w_branch_bad) begin
        w_in_sel    = PcSelBranch;
        w_in_target = i_branch_target;
      end
    end
  end

  // Ties go to the fresh input; an empty pending entry is PcSelInc.
  always_comb begin
    o_sel    = i_pend_sel;
    o_target = i_pend_target;
    if (w_in_sel >= i_pend_sel) begin
      o_sel    = w_in_sel;
      o_target = w_in_target;
    end
  end

  assign o_misaligned = i_enable && ((i_jump && w_jump_bad) || (i_branch && w_branch_bad));
  assign o_badaddr    = (i_jump && w_jump_bad) ? i_jump_target : i_branch_target;

endmodule

// File: rtl/panda_pc_unit.sv
// Program-counter unit for the fetch stage: boot address, prioritised
// redirects, stall with one-entry redirect buffer, fetch valid/ready.
module panda_pc_unit
  import panda_pkg::*;
#(
  parameter int               Width     = 32,
  parameter logic [Width-1:0] BootAddr  = Width'(32'h8000_0000),
  parameter int               AlignBits = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  panda_pc_unit_if.slave  bus
);

  localparam logic [Width-1:0] IncStep = Width'(1) << AlignBits;

  pc_state_e        r_state;
  pc_state_e        w_state_next;
  logic [Width-1:0] r_pc;
  logic [Width-1:0] w_pc_next;
  pc_sel_e          r_pend_sel;
  pc_sel_e          w_pend_sel_next;
  logic [Width-1:0] r_pend_target;
  logic [Width-1:0] w_pend_target_next;
  logic             r_flush;
  logic             w_flush_next;
  logic             r_misaligned;
  logic [Width-1:0] r_badaddr;

  logic             w_active;
  pc_sel_e          w_sel;
  logic [Width-1:0] w_target;
  logic             w_misaligned;
  logic [Width-1:0] w_badaddr;

  assign w_active = (r_state != PcBoot);

  panda_pc_redirect_arb #(
    .Width     (Width),
    .AlignBits (AlignBits)
  ) u_arb (
    .i_enable        (w_active),
    .i_branch        (bus.branch_i),
    .i_branch_target (bus.branch_target_i),
    .i_jump          (bus.jump_i),
    .i_jump_target   (bus.jump_target_i),
    .i_mret          (bus.mret_i),
    .i_mepc          (bus.mepc_i),
    .i_trap          (bus.trap_i),
    .i_trap_vector   (bus.trap_vector_i),
    .i_pend_sel      (r_pend_sel),
    .i_pend_target   (r_pend_target),
    .o_sel           (w_sel),
    .o_target        (w_target),
    .o_misaligned    (w_misaligned),
    .o_badaddr       (w_badaddr)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      PcBoot:  w_state_next = PcRun;
      PcRun:   w_state_next = bus.stall_i ? PcHold : PcRun;
      PcHold:  w_state_next = bus.stall_i ? PcHold : PcRun;
      default: w_state_next = PcBoot;
    endcase
  end

  // While stalled the arbiter result already holds max(input, pending),
  // so the buffer just takes it; otherwise any redirect overrides ready.
  always_comb begin
    w_pc_next          = r_pc;
    w_pend_sel_next    = r_pend_sel;
    w_pend_target_next = r_pend_target;
    w_flush_next       = 1'b0;
    if (w_active) begin
      if (bus.stall_i) begin
        w_pend_sel_next    = w_sel;
        w_pend_target_next = w_target;
      end else if (w_sel != PcSelInc) begin
        w_pc_next          = w_target;
        w_flush_next       = 1'b1;
        w_pend_sel_next    = PcSelInc;
        w_pend_target_next = '0;
      end else if (bus.fetch_ready_i) begin
        w_pc_next = r_pc + IncStep;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= PcBoot;
      r_pc          <= BootAddr;
      r_pend_sel    <= PcSelInc;
      r_pend_target <= '0;
      r_flush       <= 1'b0;
      r_misaligned  <= 1'b0;
      r_badaddr     <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_pend_sel    <= w_pend_sel_next;
      r_pend_target <= w_pend_target_next;
      r_flush       <= w_flush_next;
      r_misaligned  <= w_misaligned;
      if (w_misaligned) begin
        r_badaddr <= w_badaddr;
      end
    end
  end

  assign bus.fetch_valid_o = w_active && !bus.stall_i;
  assign bus.pc_o          = r_pc;
  assign bus.pc_inc_o      = r_pc + IncStep;
  assign bus.flush_o       = r_flush;
  assign bus.misaligned_o  = r_misaligned;
  assign bus.badaddr_o     = r_badaddr;

endmodule

// File: tb/tb_panda_pc_unit.sv
// Scoreboard bench for panda_pc_unit: stimulus queues the expected per-cycle
// outputs, a monitor on the falling edge pops and compares them.
module tb_panda_pc_unit;

  logic clk;
  logic rst_na;
  logic rst_nb;
  int   cyc;
  int   checks;
  int   errors;

  panda_pc_unit_if #(.Width(32)) ifa ();
  panda_pc_unit_if #(.Width(32)) ifb ();

  panda_pc_unit #(
    .Width     (32),
    .BootAddr  (32'h8000_0000),
    .AlignBits (2)
  ) dut_a (
    .clk_i  (clk),
    .rst_ni (rst_na),
    .bus    (ifa)
  );

  panda_pc_unit #(
    .Width     (32),
    .BootAddr  (32'hFFFF_FFF8),
    .AlignBits (2)
  ) dut_b (
    .clk_i  (clk),
    .rst_ni (rst_nb),
    .bus    (ifb)
  );

  typedef struct {
    int          cyc;
    bit          dut;
    string       nm;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_inc;
    logic        flush;
    logic        mis;
    logic [31:0] bad;
  } exp_t;

  exp_t q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
    ifa.branch_i = 1'b0; ifa.jump_i = 1'b0; ifa.mret_i = 1'b0; ifa.trap_i = 1'b0;
    ifb.branch_i = 1'b0; ifb.jump_i = 1'b0; ifb.mret_i = 1'b0; ifb.trap_i = 1'b0;
  endtask

  // Expected outputs visible during the current cycle.
  task automatic expect_out(input bit d, input string nm, input logic v,
                            input logic [31:0] pc, input logic [31:0] pc_inc,
                            input logic fl, input logic mis, input logic [31:0] bad);
    exp_t e;
    e.cyc = cyc; e.dut = d; e.nm = nm; e.valid = v; e.pc = pc;
    e.pc_inc = pc_inc; e.flush = fl; e.mis = mis; e.bad = bad;
    q.push_back(e);
  endtask

  initial begin
    exp_t        e;
    logic        v, fl, mis;
    logic [31:0] pc, pci, bad;
    checks = 0;
    errors = 0;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.dut) begin
          v = ifb.fetch_valid_o; pc = ifb.pc_o; pci = ifb.pc_inc_o;
          fl = ifb.flush_o; mis = ifb.misaligned_o; bad = ifb.badaddr_o;
        end else begin
          v = ifa.fetch_valid_o; pc = ifa.pc_o; pci = ifa.pc_inc_o;
          fl = ifa.flush_o; mis = ifa.misaligned_o; bad = ifa.badaddr_o;
        end
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL %s: sampled late, cycle %0d required %0d", e.nm, cyc, e.cyc);
        end else if (v !== e.valid || pc !== e.pc || pci !== e.pc_inc ||
                     fl !== e.flush || mis !== e.mis || bad !== e.bad) begin
          errors++;
          $display("FAIL %s: got v=%b pc=%h inc=%h fl=%b mis=%b bad=%h required v=%b pc=%h inc=%h fl=%b mis=%b bad=%h",
                   e.nm, v, pc, pci, fl, mis, bad,
                   e.valid, e.pc, e.pc_inc, e.flush, e.mis, e.bad);
        end else begin
          $display("chk %-14s dut%0d v=%b pc=%h fl=%b mis=%b ok", e.nm, e.dut, v, pc, fl, mis);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_na = 1'b0;
    rst_nb = 1'b0;
    ifa.stall_i = 1'b0; ifa.fetch_ready_i = 1'b1;
    ifa.branch_i = 1'b0; ifa.branch_target_i = '0; ifa.jump_i = 1'b0; ifa.jump_target_i = '0;
    ifa.mret_i = 1'b0; ifa.mepc_i = '0; ifa.trap_i = 1'b0; ifa.trap_vector_i = '0;
    ifb.stall_i = 1'b0; ifb.fetch_ready_i = 1'b1;
    ifb.branch_i = 1'b0; ifb.branch_target_i = '0; ifb.jump_i = 1'b0; ifb.jump_target_i = '0;
    ifb.mret_i = 1'b0; ifb.mepc_i = '0; ifb.trap_i = 1'b0; ifb.trap_vector_i = '0;
    repeat (2) tick();

    // Reset release and sequential fetch
    rst_na = 1'b1;
    expect_out(0, "boot", 0, 32'h8000_0000, 32'h8000_0004, 0, 0, 0);
    tick(); expect_out(0, "first_fetch", 1, 32'h8000_0000, 32'h8000_0004, 0, 0, 0);
    tick(); expect_out(0, "inc1", 1, 32'h8000_0004, 32'h8000_0008, 0, 0, 0);
    tick(); expect_out(0, "inc2", 1, 32'h8000_0008, 32'h8000_000C, 0, 0, 0);
    ifa.branch_i = 1'b1; ifa.branch_target_i = 32'h8000_0018;
    ifa.jump_i   = 1'b1; ifa.jump_target_i   = 32'h8000_0038;
    tick(); expect_out(0, "jump_wins", 1, 32'h8000_0038, 32'h8000_003C, 1, 0, 0);
    tick(); expect_out(0, "after_jump", 1, 32'h8000_003C, 32'h8000_0040, 0, 0, 0);

    // Stall with buffered redirects: trap must outrank the later jump
    tick(); ifa.stall_i = 1'b1; ifa.branch_i = 1'b1; ifa.branch_target_i = 32'h0000_0100;
    expect_out(0, "stall1", 0, 32'h8000_0040, 32'h8000_0044, 0, 0, 0);
    tick(); ifa.trap_i = 1'b1; ifa.trap_vector_i = 32'h0000_0200;
    expect_out(0, "stall2", 0, 32'h8000_0040, 32'h8000_0044, 0, 0, 0);
    tick(); ifa.jump_i = 1'b1; ifa.jump_target_i = 32'h0000_0300;
    expect_out(0, "stall3", 0, 32'h8000_0040, 32'h8000_0044, 0, 0, 0);
    tick(); expect_out(0, "stall4", 0, 32'h8000_0040, 32'h8000_0044, 0, 0, 0);
    tick(); ifa.stall_i = 1'b0;
    expect_out(0, "release", 1, 32'h8000_0040, 32'h8000_0044, 0, 0, 0);
    tick(); expect_out(0, "pend_trap", 1, 32'h0000_0200, 32'h0000_0204, 1, 0, 0);
    tick(); expect_out(0, "after_trap", 1, 32'h0000_0204, 32'h0000_0208, 0, 0, 0);

    // Misaligned jump is dropped
    ifa.jump_i = 1'b1; ifa.jump_target_i = 32'h8000_0042;
    tick(); expect_out(0, "misaligned", 1, 32'h0000_0208, 32'h0000_020C, 0, 1, 32'h8000_0042);
    tick(); expect_out(0, "mis_clear", 1, 32'h0000_020C, 32'h0000_0210, 0, 0, 32'h8000_0042);

    // Ready low holds pc; mret redirects anyway with mepc masked
    ifa.fetch_ready_i = 1'b0;
    tick(); expect_out(0, "nready1", 1, 32'h0000_020C, 32'h0000_0210, 0, 0, 32'h8000_0042);
    tick(); expect_out(0, "nready2", 1, 32'h0000_020C, 32'h0000_0210, 0, 0, 32'h8000_0042);
    ifa.mret_i = 1'b1; ifa.mepc_i = 32'h8000_0103;
    tick(); ifa.fetch_ready_i = 1'b1;
    expect_out(0, "mret", 1, 32'h8000_0100, 32'h8000_0104, 1, 0, 32'h8000_0042);
    tick(); expect_out(0, "after_mret", 1, 32'h8000_0104, 32'h8000_0108, 0, 0, 32'h8000_0042);

    // Trap beats mret in the same cycle; trap vector masked
    ifa.trap_i = 1'b1; ifa.trap_vector_i = 32'h0000_0403;
    ifa.mret_i = 1'b1; ifa.mepc_i = 32'h0000_0500;
    tick(); expect_out(0, "trap_vs_mret", 1, 32'h0000_0400, 32'h0000_0404, 1, 0, 32'h8000_0042);
    tick(); expect_out(0, "after_tvm", 1, 32'h0000_0404, 32'h0000_0408, 0, 0, 32'h8000_0042);

    // Wraparound near top of address space
    rst_nb = 1'b1;
    expect_out(1, "b_boot", 0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0, 0, 0);
    tick(); expect_out(1, "b_first", 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0, 0, 0);
    tick(); expect_out(1, "b_top", 1, 32'hFFFF_FFFC, 32'h0000_0000, 0, 0, 0);
    tick(); ifb.stall_i = 1'b1; ifb.trap_i = 1'b1; ifb.trap_vector_i = 32'h0000_0600;
    expect_out(1, "b_wrap_stall", 0, 32'h0000_0000, 32'h0000_0004, 0, 0, 0);
    tick(); expect_out(1, "b_pending", 0, 32'h0000_0000, 32'h0000_0004, 0, 0, 0);

    // Reset mid-stall discards the pending trap
    tick(); rst_nb = 1'b0;
    expect_out(1, "b_reset", 0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0, 0, 0);
    tick(); rst_nb = 1'b1; ifb.stall_i = 1'b0;
    expect_out(1, "b_reboot", 0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0, 0, 0);
    tick(); expect_out(1, "b_no_trap", 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0, 0, 0);
    tick(); expect_out(1, "b_no_flush", 1, 32'hFFFF_FFFC, 32'h0000_0000, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
